// File: rtl/tlc_phase_scheduler_pkg.sv
// Shared phase and light encodings for the two-road phase scheduler.
package tlc_pkg;

    typedef enum logic [2:0] {
        A_GREEN  = 3'd0,
        A_YELLOW = 3'd1,
        RED_AB   = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        RED_BA   = 3'd5,
        PED_WALK = 3'd6
    } tlc_state_t;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10
    } tlc_light_t;

    function automatic tlc_light_t light_of(input tlc_state_t s, input logic road_b);
        light_of = RED;
        case (s)
            A_GREEN:  if (!road_b) light_of = GREEN;
            A_YELLOW: if (!road_b) light_of = YELLOW;
            B_GREEN:  if (road_b)  light_of = GREEN;
            B_YELLOW: if (road_b)  light_of = YELLOW;
            default:  light_of = RED;
        endcase
    endfunction

endpackage

// File: rtl/tlc_phase_scheduler_if.sv
// Sensor inputs and light/timer outputs of the phase scheduler.
interface tlc_phase_scheduler_if #(
    parameter int TW = 4
);
    logic          car_a;
    logic          car_b;
    logic          ped_req;
    logic [1:0]    rA;
    logic [1:0]    rB;
    logic [2:0]    state;
    logic [TW-1:0] timer_display;
    logic          walk;
    logic          ped_pending;

    modport master (
        output car_a, car_b, ped_req,
        input  rA, rB, state, timer_display, walk, ped_pending
    );

    modport slave (
        input  car_a, car_b, ped_req,
        output rA, rB, state, timer_display, walk, ped_pending
    );
endinterface

// File: rtl/tlc_phase_scheduler_timer.sv
// Phase down-counter: load wins, otherwise decrement and saturate at zero.
module tlc_phase_timer #(
    parameter int            TW      = 4,
    parameter logic [TW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [TW-1:0] i_value,
    output logic [TW-1:0] o_cnt
);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Demand-actuated two-road phase scheduler with countdown display.
// Optional pedestrian walk phase enabled by defining TLC_PED_WALK_EN.
module tlc_phase_scheduler
    import tlc_pkg::*;
#(
    parameter int TW        = 4,
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 10,
    parameter int YELLOW    = 2,
    parameter int ALL_RED   = 1,
    parameter int WALK      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    tlc_phase_scheduler_if.slave  bus
);

    localparam logic [TW-1:0] GREEN_LD   = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YELLOW_LD  = TW'(YELLOW - 1);
    localparam logic [TW-1:0] RED_LD     = TW'(ALL_RED - 1);
    localparam logic [TW-1:0] WALK_LD    = TW'(WALK - 1);
    localparam logic [TW:0]   GREEN_EXIT = (TW+1)'(MAX_GREEN - MIN_GREEN);

    tlc_state_t    r_state;
    logic [1:0]    r_rA;
    logic [1:0]    r_rB;
    logic          r_walk;
    logic          r_ped_pending;

    tlc_state_t    w_next;
    logic          w_load;
    logic [TW-1:0] w_load_val;
    logic [TW-1:0] w_cnt;
    logic          w_green_done;
    logic          w_unused_ped;

    // Once the minimum green has elapsed, cnt sits at or below GREEN_EXIT.
    assign w_green_done = ({1'b0, w_cnt} <= GREEN_EXIT);
    assign w_unused_ped = bus.ped_req;

    always_comb begin
        w_next = r_state;
        case (r_state)
            A_GREEN:  if ((bus.car_b | r_ped_pending) && w_green_done) w_next = A_YELLOW;
            A_YELLOW: if (w_cnt == '0) w_next = RED_AB;
            RED_AB:   if (w_cnt == '0) w_next = B_GREEN;
            B_GREEN:  if ((bus.car_a | r_ped_pending) && w_green_done) w_next = B_YELLOW;
            B_YELLOW: if (w_cnt == '0) w_next = RED_BA;
`ifdef TLC_PED_WALK_EN
            RED_BA:   if (w_cnt == '0) w_next = r_ped_pending ? PED_WALK : A_GREEN;
`else
            RED_BA:   if (w_cnt == '0) w_next = A_GREEN;
`endif
            PED_WALK: if (w_cnt == '0) w_next = A_GREEN;
            default:  w_next = A_GREEN;
        endcase
    end

    always_comb begin
        w_load = (w_next != r_state);
        case (w_next)
            A_GREEN, B_GREEN:   w_load_val = GREEN_LD;
            A_YELLOW, B_YELLOW: w_load_val = YELLOW_LD;
            RED_AB, RED_BA:     w_load_val = RED_LD;
            PED_WALK:           w_load_val = WALK_LD;
            default:            w_load_val = GREEN_LD;
        endcase
    end

    tlc_phase_timer #(
        .TW      (TW),
        .RST_VAL (GREEN_LD)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_cnt   (w_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= A_GREEN;
            r_rA          <= GREEN;
            r_rB          <= RED;
            r_walk        <= 1'b0;
            r_ped_pending <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rA    <= light_of(w_next, 1'b0);
            r_rB    <= light_of(w_next, 1'b1);
`ifdef TLC_PED_WALK_EN
            r_walk  <= (w_next == PED_WALK);
            // A request arriving on the walk-entry edge outranks the clear.
            if (bus.ped_req)
                r_ped_pending <= 1'b1;
            else if (w_next == PED_WALK && r_state != PED_WALK)
                r_ped_pending <= 1'b0;
`else
            r_walk        <= 1'b0;
            r_ped_pending <= 1'b0;
`endif
        end
    end

    assign bus.state         = r_state;
    assign bus.rA            = r_rA;
    assign bus.rB            = r_rB;
    assign bus.timer_display = w_cnt;
    assign bus.walk          = r_walk;
    assign bus.ped_pending   = r_ped_pending;

endmodule
